// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions.
// Used by the fetch, operand-fetch and writeback stages.
package wb_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_W  = 5;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-to-writeback handshake bundle.
// The master is the memory stage; the slave is wb_stage.
interface wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instruction;
  logic              in_RegWrite;
  logic              in_RegDst;
  logic              in_MemtoReg;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;

  modport master (
    output in_valid, in_instruction, in_RegWrite,
    output in_RegDst, in_MemtoReg,
    output in_alu_result, in_mem_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_instruction, in_RegWrite,
    input  in_RegDst, in_MemtoReg,
    input  in_alu_result, in_mem_data,
    output in_ready
  );
endinterface

// File: rtl/wb_stage_entry_reg.sv
// MEM/WB entry register and retire counter.
// An emptied entry is cleared so stale data never leaks out.
module wb_entry_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              retire,
  input  logic              flush,
  input  logic              nxt_we,
  input  logic [REG_AW-1:0] nxt_dest,
  input  logic [DATA_W-1:0] nxt_data,
  output logic              valid,
  output logic              we,
  output logic [REG_AW-1:0] dest,
  output logic [DATA_W-1:0] data,
  output logic [31:0]       count
);
  logic              valid_q;
  logic              we_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else if (flush || (retire && !load)) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      we_q    <= nxt_we;
      dest_q  <= nxt_dest;
      data_q  <= nxt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (retire)
      count_q <= count_q + 32'd1;
  end

  assign valid = valid_q;
  assign we    = we_q;
  assign dest  = dest_q;
  assign data  = data_q;
  assign count = count_q;
endmodule

// File: rtl/wb_stage_mux.sv
// Generic two-input multiplexer.
// Selects b when sel is high, otherwise a.
module MUX_2x1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select,
// register-file write port, bypass and retire count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_if.slave         mem,
  input  logic              flush,
  input  logic              rf_busy,
  output logic              RegWrite,
  output logic [REG_AW-1:0] writereg,
  output logic [DATA_W-1:0] writedata,
  input  logic [REG_AW-1:0] fwd_rs_addr,
  input  logic [REG_AW-1:0] fwd_rt_addr,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retire_count
);
  logic              valid;
  logic              we;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] data;
  logic              load;
  logic              retire;
  logic [REG_AW-1:0] nxt_dest;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_we;
  logic              unused_bits;

  MUX_2x1 #(.W(REG_AW)) u_dst_mux (
    .a   (mem.in_instruction[RT_LSB +: REG_AW]),
    .b   (mem.in_instruction[RD_LSB +: REG_AW]),
    .sel (mem.in_RegDst),
    .y   (nxt_dest)
  );

  MUX_2x1 #(.W(DATA_W)) u_res_mux (
    .a   (mem.in_alu_result),
    .b   (mem.in_mem_data),
    .sel (mem.in_MemtoReg),
    .y   (nxt_data)
  );

  // $zero writes are dropped here so bypass never matches r0
  assign nxt_we = mem.in_RegWrite
                && (nxt_dest != REG_AW'(REG_ZERO));

  assign mem.in_ready = !flush && (!valid || !rf_busy);
  assign load         = mem.in_valid && mem.in_ready;
  assign retire       = valid && !rf_busy && !flush;

  wb_entry_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_entry (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .retire   (retire),
    .flush    (flush),
    .nxt_we   (nxt_we),
    .nxt_dest (nxt_dest),
    .nxt_data (nxt_data),
    .valid    (valid),
    .we       (we),
    .dest     (dest),
    .data     (data),
    .count    (retire_count)
  );

  assign RegWrite   = retire && we;
  assign writereg   = valid ? dest : '0;
  assign writedata  = valid ? data : '0;
  assign fwd_rs_hit = valid && we && (dest == fwd_rs_addr);
  assign fwd_rt_hit = valid && we && (dest == fwd_rt_addr);
  assign fwd_data   = data;

  assign unused_bits = ^{mem.in_instruction[31:21],
                         mem.in_instruction[10:0]};
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage processor: holds the MEM/WB pipeline register, selects the result (ALU result or load data), resolves the destination register, and drives the register file's write port (`RegWrite`, `writereg`, `writedata`). It also supplies same-cycle bypass data to the operand-fetch stage and counts retired instructions. It sits between the memory stage (upstream, valid/ready) and the register file (downstream, which can refuse a write via `rf_busy`).

## Interface

**Parameters**
- `DATA_W`, 32, datapath width.
- `REG_AW`, 5, register address width.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instruction`  in  32  instruction word; rt = [20:16], rd = [15:11].
- `in_RegWrite`  in  1  instruction writes a register.
- `in_RegDst`  in  1  destination select: 0 = rt, 1 = rd.
- `in_MemtoReg`  in  1  result select: 0 = ALU result, 1 = memory data.
- `in_alu_result`  in  DATA_W  ALU result.
- `in_mem_data`  in  DATA_W  load data.
- `flush`  in  1  discard the held entry and block the load this cycle.
- `rf_busy`  in  1  register file cannot accept a write this cycle.
- `RegWrite`  out  1  write strobe to the register file.
- `writereg`  out  REG_AW  write address.
- `writedata`  out  DATA_W  write data.
- `fwd_rs_addr`, `fwd_rt_addr`  in  REG_AW  source addresses of the instruction in operand fetch.
- `fwd_rs_hit`, `fwd_rt_hit`  out  1  held entry will write that source.
- `fwd_data`  out  DATA_W  held entry's result.
- `retire_count`  out  32  number of retired instructions.

## Operation

- **Entry capture.** One-entry register {`valid`, `we`, `dest`, `data`}, captured on load.
  - `dest` = `in_RegDst ? in_instruction[15:11] : in_instruction[20:16]`.
  - `data` = `in_MemtoReg ? in_mem_data : in_alu_result`.
  - `we` = `in_RegWrite && dest != 0`. Writes to $zero are suppressed at capture.
- **State machine.** Two states.
  - EMPTY (`valid` = 0) → FULL on load.
  - FULL → EMPTY on retire without load, or on flush.
  - FULL → FULL on retire with a simultaneous load, or while `rf_busy` holds.
- **Retire.** `retire` = `valid && !rf_busy && !flush`.
- **Ready and load.**
  - `in_ready` = `!valid || (!rf_busy && !flush)`, except `in_ready` = 0 whenever `flush` = 1.
  - `load` = `in_valid && in_ready`.
- **Register-file write.**
  - `RegWrite` = `retire && we`.
  - `writereg` and `writedata` show `dest` and `data` whenever `valid`; otherwise 0.
- **Bypass.**
  - `fwd_rs_hit` = `valid && we && dest == fwd_rs_addr`; `fwd_rt_hit` is the same with `fwd_rt_addr`.
  - `fwd_data` = `data`.
  - Hits stay asserted while `rf_busy` holds the entry.
- **Retire counter.** `retire_count` increments by 1 on every retire, whether or not the instruction writes. It wraps from 0xFFFFFFFF to 0.
- **Priorities.**
  - `flush` beats retire and load; a flushed entry is not counted.
  - Retire and load in the same cycle is legal: the new entry replaces the old one at the edge.

## Timing

- **Reset.** `valid`, `we`, `dest`, `data`, and `retire_count` are 0. `RegWrite` = 0, `writereg` = 0, `writedata` = 0. No hits; `fwd_data` = 0. `in_ready` = 1.
- **Latency.** An instruction accepted at edge N drives `RegWrite` during cycle N+1 if `rf_busy` = 0; the register file commits at edge N+2.
- **Throughput.** One instruction per cycle while `rf_busy` = 0.
- **Back-pressure.** `rf_busy` stalls the entry with no bubble insertion. `in_ready` depends combinationally on `rf_busy` and `flush`; there is no combinational path from `in_valid` to `in_ready`.
- **Reset mid-operation.** Reset asserted while FULL drops the entry immediately (asynchronous); no write strobe is issued.

## Structure

- **Shared package** (shared with the fetch and operand-fetch stages):
  - field positions `RS_LSB` = 21, `RT_LSB` = 16, `RD_LSB` = 11;
  - `REG_ZERO` = 5'd0;
  - the entry record type {`valid`, `we`, `dest`, `data`}.
- **Sub-modules.** Destination and result selection reuse the existing `MUX_2x1`. The entry register plus the counter is a natural sub-module, `wb_entry_reg`.

## Test plan

- **Load, rd destination.** Accept `in_RegDst` = 1, rd = 5, `in_MemtoReg` = 1, `in_mem_data` = 0xDEADBEEF, `in_RegWrite` = 1 → the next cycle shows `RegWrite` = 1, `writereg` = 5, `writedata` = 0xDEADBEEF; `retire_count` goes 0 → 1.
- **$zero suppression.** Write to $zero with `in_RegDst` = 0, rt = 0, `in_RegWrite` = 1 → `RegWrite` stays 0, `fwd_*_hit` stay 0, `retire_count` still increments.
- **Back-pressure.** Hold `rf_busy` = 1 for 3 cycles while FULL with dest = 7 → `in_ready` = 0 and `RegWrite` = 0 for those cycles, and `fwd_rs_hit` = 1 when `fwd_rs_addr` = 7. After release: one write, then `in_ready` = 1.
- **Back-to-back.** Stream 4 instructions with `rf_busy` = 0 → 4 consecutive `RegWrite` pulses in order; `retire_count` = 4.
- **Flush.** Assert `flush` while FULL with `in_valid` = 1 → no `RegWrite`, the entry is gone at the next edge, the incoming instruction is not loaded, and `retire_count` is unchanged.
- **Reset mid-operation and wrap.** Assert `rst_n` = 0 mid-stream → all outputs 0 asynchronously. Separately, force `retire_count` = 0xFFFFFFFF and retire once → count = 0.
